// File: rtl/vdc_slot_arbiter_if.sv
// Slot-arbiter bus: CRTC timing, register snapshot and requests in; grant, acks and status out.
interface vdc_slot_arbiter_if #(parameter int RFSH_BITS = 8);
  logic                 slot;
  logic                 done;
  logic [7:0]           col;
  logic [7:0]           reg_ht;
  logic [7:0]           reg_hd;
  logic [3:0]           reg_drr;
  logic                 req_char;
  logic                 req_scrn;
  logic                 req_attr;
  logic                 req_cpu;
  logic [2:0]           grant;
  logic                 grant_stb;
  logic                 ack_char;
  logic                 ack_scrn;
  logic                 ack_attr;
  logic                 ack_cpu;
  logic [RFSH_BITS-1:0] rfsh_addr;
  logic [4:0]           starve_cnt;

  modport master (
    output slot, done, col, reg_ht, reg_hd, reg_drr,
           req_char, req_scrn, req_attr, req_cpu,
    input  grant, grant_stb, ack_char, ack_scrn, ack_attr, ack_cpu,
           rfsh_addr, starve_cnt
  );

  modport slave (
    input  slot, done, col, reg_ht, reg_hd, reg_drr,
           req_char, req_scrn, req_attr, req_cpu,
    output grant, grant_stb, ack_char, ack_scrn, ack_attr, ack_cpu,
           rfsh_addr, starve_cnt
  );
endinterface

// File: rtl/vdc_slot_arbiter.sv
// Per-column RAM slot arbiter for the VDC: one registered grant per slot, one ack per completed slot.
// Optional macro VDC_CPU_GUARANTEE_EN lets a starved CPU override RFSH/SCRN/ATTR (never CHAR).
module vdc_slot_arbiter #(
  parameter int RFSH_BITS    = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  vdc_slot_arbiter_if.slave   bus
);

  localparam logic [2:0] G_NONE = 3'd0;
  localparam logic [2:0] G_CHAR = 3'd1;
  localparam logic [2:0] G_RFSH = 3'd2;
  localparam logic [2:0] G_SCRN = 3'd3;
  localparam logic [2:0] G_ATTR = 3'd4;
  localparam logic [2:0] G_CPU  = 3'd5;

`ifdef VDC_CPU_GUARANTEE_EN
  localparam bit GUARANTEE = 1'b1;
`else
  localparam bit GUARANTEE = 1'b0;
`endif
  localparam int          LIM_CLAMP = (STARVE_LIMIT > 63) ? 63 : STARVE_LIMIT;
  localparam logic [5:0]  LIM       = 6'(LIM_CLAMP);

  logic [7:0] ht_m2;
  logic [8:0] rfsh_end;
  logic       en_int, en_rfsh, cpu_force;
  logic [2:0] nxt_grant;
  logic       active;

  assign ht_m2    = bus.reg_ht - 8'd2;
  assign en_int   = (bus.reg_ht < 8'd2) || (bus.col < 8'd2) || (bus.col >= ht_m2);
  assign rfsh_end = {1'b0, bus.reg_hd} + {5'b0, bus.reg_drr};
  assign en_rfsh  = (bus.col >= bus.reg_hd) && ({1'b0, bus.col} < rfsh_end);
  assign cpu_force = GUARANTEE && bus.req_cpu && ({1'b0, bus.starve_cnt} >= LIM);

  always_comb begin
    nxt_grant = G_NONE;
    if (bus.req_char)                                     nxt_grant = G_CHAR;
    else if (cpu_force)                                   nxt_grant = G_CPU;
    else if (!en_int && en_rfsh && bus.reg_drr != 4'd0)   nxt_grant = G_RFSH;
    else if (!en_int && bus.req_scrn)                     nxt_grant = G_SCRN;
    else if (!en_int && bus.req_attr)                     nxt_grant = G_ATTR;
    else if (bus.req_cpu)                                 nxt_grant = G_CPU;
  end

  // active marks a granted slot still waiting for done; it gates the single ack per slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.grant      <= G_NONE;
      bus.grant_stb  <= 1'b0;
      bus.ack_char   <= 1'b0;
      bus.ack_scrn   <= 1'b0;
      bus.ack_attr   <= 1'b0;
      bus.ack_cpu    <= 1'b0;
      bus.rfsh_addr  <= '0;
      bus.starve_cnt <= 5'd0;
      active         <= 1'b0;
    end else begin
      bus.grant_stb <= 1'b0;
      bus.ack_char  <= 1'b0;
      bus.ack_scrn  <= 1'b0;
      bus.ack_attr  <= 1'b0;
      bus.ack_cpu   <= 1'b0;
      if (bus.done && active) begin
        bus.ack_char <= (bus.grant == G_CHAR);
        bus.ack_scrn <= (bus.grant == G_SCRN);
        bus.ack_attr <= (bus.grant == G_ATTR);
        bus.ack_cpu  <= (bus.grant == G_CPU);
        active       <= 1'b0;
      end
      // A new slot overrides the done bookkeeping above: the outgoing grant is acked first.
      if (bus.slot) begin
        bus.grant     <= nxt_grant;
        bus.grant_stb <= 1'b1;
        active        <= 1'b1;
        if (nxt_grant == G_RFSH)
          bus.rfsh_addr <= bus.rfsh_addr + 1'b1;
        if (nxt_grant == G_CPU || !bus.req_cpu)
          bus.starve_cnt <= 5'd0;
        else if (bus.starve_cnt != 5'd31)
          bus.starve_cnt <= bus.starve_cnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_vdc_slot_arbiter.sv
// Directed self-checking bench for vdc_slot_arbiter; honours VDC_CPU_GUARANTEE_EN like the RTL.
module tb_vdc_slot_arbiter;
  localparam logic [2:0] G_NONE = 3'd0, G_CHAR = 3'd1, G_RFSH = 3'd2,
                         G_SCRN = 3'd3, G_ATTR = 3'd4, G_CPU  = 3'd5;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  vdc_slot_arbiter_if #(.RFSH_BITS(8)) bus ();

  vdc_slot_arbiter #(.RFSH_BITS(8), .STARVE_LIMIT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on negedge; outputs are sampled on the negedge after the active edge.
  task automatic do_slot(input logic [7:0] c, input logic with_done);
    @(negedge clk);
    bus.slot = 1'b1; bus.done = with_done; bus.col = c;
    @(negedge clk);
    bus.slot = 1'b0; bus.done = 1'b0;
  endtask

  task automatic do_done();
    @(negedge clk);
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
  endtask

  task automatic chk_acks(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, bus.ack_char, bus.ack_scrn, bus.ack_attr, bus.ack_cpu}, {28'd0, exp});
  endtask

  initial begin
    reset = 1'b1;
    bus.slot = 0; bus.done = 0; bus.col = 0;
    bus.reg_ht = 8'd126; bus.reg_hd = 8'd80; bus.reg_drr = 4'd5;
    bus.req_char = 0; bus.req_scrn = 0; bus.req_attr = 0; bus.req_cpu = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_grant", bus.grant, G_NONE);
    check("rst_stb", bus.grant_stb, 0);
    check("rst_rfsh", bus.rfsh_addr, 0);
    check("rst_starve", bus.starve_cnt, 0);
    chk_acks("rst_acks", 4'b0000);

    // Idle slot
    do_slot(8'd40, 1'b0);
    check("idle_grant", bus.grant, G_NONE);
    check("idle_stb", bus.grant_stb, 1);
    check("idle_rfsh", bus.rfsh_addr, 0);
    @(negedge clk);
    check("idle_stb_drop", bus.grant_stb, 0);
    do_done();
    chk_acks("idle_no_ack", 4'b0000);

    // Refresh window cols 80..84, then screen fetch
    bus.req_scrn = 1;
    for (int c = 80; c <= 86; c++) begin
      do_slot(8'(c), 1'b0);
      if (c <= 84) begin
        check($sformatf("rfsh_grant_c%0d", c), bus.grant, G_RFSH);
        check($sformatf("rfsh_addr_c%0d", c), bus.rfsh_addr, 32'(c - 79));
      end else begin
        check($sformatf("scrn_grant_c%0d", c), bus.grant, G_SCRN);
        check($sformatf("scrn_addr_c%0d", c), bus.rfsh_addr, 5);
      end
    end
    bus.req_scrn = 0;

    // CHAR beats CPU
    bus.req_char = 1; bus.req_cpu = 1;
    do_slot(8'd10, 1'b0);
    check("char_grant", bus.grant, G_CHAR);
    check("char_starve", bus.starve_cnt, 1);
    bus.req_char = 0; bus.req_cpu = 0;
    do_done();
    chk_acks("char_ack", 4'b1000);
    @(negedge clk);
    chk_acks("char_ack_pulse", 4'b0000);
    do_done();
    chk_acks("char_second_done", 4'b0000);

    // CPU in interrupt window beats SCRN
    bus.req_cpu = 1; bus.req_scrn = 1;
    do_slot(8'd124, 1'b0);
    check("cpu124_grant", bus.grant, G_CPU);
    check("cpu124_starve", bus.starve_cnt, 0);
    do_done();
    chk_acks("cpu124_ack", 4'b0001);
    do_slot(8'd123, 1'b0);
    check("scrn123_grant", bus.grant, G_SCRN);
    check("scrn123_starve", bus.starve_cnt, 1);
    do_slot(8'd1, 1'b0);
    check("cpu1_grant", bus.grant, G_CPU);
    check("cpu1_starve", bus.starve_cnt, 0);
    do_done();
    chk_acks("cpu1_ack", 4'b0001);

    // reg_drr=0 disables refresh; reg_ht<2 makes every column interrupt
    bus.req_cpu = 0;
    bus.reg_drr = 4'd0;
    do_slot(8'd80, 1'b0);
    check("drr0_grant", bus.grant, G_SCRN);
    check("drr0_rfsh", bus.rfsh_addr, 5);
    bus.reg_drr = 4'd5;
    bus.reg_ht = 8'd1; bus.req_cpu = 1;
    do_slot(8'd50, 1'b0);
    check("ht1_grant", bus.grant, G_CPU);
    bus.reg_ht = 8'd126; bus.req_cpu = 0;

    // SCRN committed, then slot+done together hands over to ATTR
    do_slot(8'd90, 1'b0);
    check("commit_scrn", bus.grant, G_SCRN);
    bus.req_scrn = 0; bus.req_attr = 1;
    do_slot(8'd91, 1'b1);
    chk_acks("slotdone_ack", 4'b0100);
    check("slotdone_grant", bus.grant, G_ATTR);
    check("slotdone_stb", bus.grant_stb, 1);
    bus.req_attr = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    do_done();
    chk_acks("rst_cancel_ack", 4'b0000);
    check("rst_cancel_grant", bus.grant, G_NONE);
    check("rst_cancel_rfsh", bus.rfsh_addr, 0);

    // Starvation at col 100 (outside interrupt and refresh windows)
    bus.req_cpu = 1; bus.req_scrn = 1;
`ifdef VDC_CPU_GUARANTEE_EN
    for (int k = 1; k <= 17; k++) begin
      do_slot(8'd100, 1'b0);
      if (k < 17) begin
        check($sformatf("starve_g_k%0d", k), bus.grant, G_SCRN);
        check($sformatf("starve_c_k%0d", k), bus.starve_cnt, 32'(k));
      end else begin
        check("guarantee_grant", bus.grant, G_CPU);
        check("guarantee_clear", bus.starve_cnt, 0);
      end
    end
`else
    for (int k = 1; k <= 33; k++) begin
      do_slot(8'd100, 1'b0);
      check($sformatf("starve_g_k%0d", k), bus.grant, G_SCRN);
      check($sformatf("starve_c_k%0d", k), bus.starve_cnt, 32'((k > 31) ? 31 : k));
    end
`endif
    bus.req_cpu = 0; bus.req_scrn = 0;
    do_slot(8'd100, 1'b0);
    check("starve_idle_clear", bus.starve_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
